// File: rtl/qam_pkg.sv
// Shared definitions for the square-QAM mapper: mode encodings, bits-per-axis
// lookup, Gray decoding and the saturation limits for the default output width.
package qam_pkg;

    typedef enum logic [1:0] {
        QAM_MODE_QPSK    = 2'd0,
        QAM_MODE_16      = 2'd1,
        QAM_MODE_64      = 2'd2,
        QAM_MODE_ILLEGAL = 2'd3
    } qam_mode_e;

    localparam int unsigned QAM_DATA_W  = 18;
    localparam int unsigned QAM_MAX_BPA = 3;
    localparam int          QAM_SAT_POS = (2 ** (QAM_DATA_W - 1)) - 1;
    localparam int          QAM_SAT_NEG = -QAM_SAT_POS;

    // Returns 0 for a mode that has no defined constellation.
    function automatic logic [1:0] mode_to_bpa(input qam_mode_e mode);
        case (mode)
            QAM_MODE_QPSK: return 2'd1;
            QAM_MODE_16:   return 2'd2;
            QAM_MODE_64:   return 2'd3;
            default:       return 2'd0;
        endcase
    endfunction

    // Bits at or above bpa are ignored before decoding.
    function automatic logic [2:0] gray2bin(input logic [2:0] g, input logic [1:0] bpa);
        logic [2:0] m;
        m = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (i < 32'(bpa)) m[i] = g[i];
        end
        return {m[2], m[2] ^ m[1], ^m};
    endfunction

endpackage

// File: rtl/qam_axis_level.sv
// One constellation axis: Gray decode ahead of stage 1, then odd-level index,
// scaling by half the reference and symmetric saturation ahead of stage 2.
module qam_axis_level
    import qam_pkg::*;
#(
    parameter int unsigned DATA_W  = QAM_DATA_W,
    parameter int unsigned MAX_BPA = QAM_MAX_BPA
) (
    input  logic [MAX_BPA-1:0]        gray_i,
    input  logic [1:0]                bpa_i,
    output logic [MAX_BPA-1:0]        idx_o,
    input  logic [MAX_BPA-1:0]        idx_s1_i,
    input  logic [1:0]                bpa_s1_i,
    input  logic                      legal_s1_i,
    input  logic signed [DATA_W-1:0]  ref_s1_i,
    output logic signed [DATA_W-1:0]  amp_o
);

    localparam logic signed [DATA_W+2:0] SAT_POS_X = {4'b0000, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W+2:0] SAT_NEG_X = -SAT_POS_X;

    logic [2:0]               g3;
    logic [2:0]               n3;
    logic [2:0]               ns1;
    logic [3:0]               top;
    logic signed [4:0]        k;
    logic signed [DATA_W-1:0] h;
    logic signed [DATA_W+2:0] k_x;
    logic signed [DATA_W+2:0] h_x;
    logic signed [DATA_W+2:0] prod;

    always_comb begin
        g3    = '0;
        idx_o = '0;
        for (int unsigned i = 0; i < MAX_BPA && i < 3; i++) g3[i] = gray_i[i];
        n3 = gray2bin(g3, bpa_i);
        for (int unsigned i = 0; i < MAX_BPA && i < 3; i++) idx_o[i] = n3[i];
    end

    always_comb begin
        ns1 = '0;
        for (int unsigned i = 0; i < MAX_BPA && i < 3; i++) ns1[i] = idx_s1_i[i];
        // k = (2^b - 1) - 2n, always odd and within +/-7
        top  = (4'd1 << bpa_s1_i) - 4'd1;
        k    = signed'({1'b0, top}) - signed'({1'b0, ns1, 1'b0});
        h    = ref_s1_i >>> 1;
        k_x  = {{(DATA_W-2){k[4]}}, k};
        h_x  = {{3{h[DATA_W-1]}}, h};
        prod = k_x * h_x;
        if (!legal_s1_i)
            amp_o = '0;
        else if (prod > SAT_POS_X)
            amp_o = SAT_POS_X[DATA_W-1:0];
        else if (prod < SAT_NEG_X)
            amp_o = SAT_NEG_X[DATA_W-1:0];
        else
            amp_o = prod[DATA_W-1:0];
    end

endmodule

// File: rtl/qam_mapper_param.sv
// Runtime-configurable QPSK/16/64-QAM mapper with a two-stage enabled pipeline;
// mode and reference travel with each symbol so reconfiguration is atomic.
module qam_mapper_param
    import qam_pkg::*;
#(
    parameter int unsigned DATA_W  = QAM_DATA_W,
    parameter int unsigned MAX_BPA = QAM_MAX_BPA
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clk_en,
    input  logic                      in_valid,
    input  logic [2*MAX_BPA-1:0]      data,
    input  logic                      cfg_load,
    input  logic [1:0]                mode_in,
    input  logic signed [DATA_W-1:0]  ref_level,
    output logic signed [DATA_W-1:0]  sig_inph,
    output logic signed [DATA_W-1:0]  sig_quad,
    output logic                      out_valid,
    output logic                      cfg_err
);

    // Modes needing more bits per axis than this build supports count as illegal.
    function automatic logic mode_ok(input qam_mode_e m);
        logic [1:0] b;
        b = mode_to_bpa(m);
        return (b != 2'd0) && (32'(b) <= MAX_BPA);
    endfunction

    qam_mode_e                cfg_mode_q, cfg_mode_d;
    logic signed [DATA_W-1:0] cfg_ref_q, cfg_ref_d;
    logic                     cfg_err_q, cfg_err_d;
    logic                     s1_valid_q, s1_valid_d;
    logic [MAX_BPA-1:0]       s1_ni_q, s1_ni_d;
    logic [MAX_BPA-1:0]       s1_nq_q, s1_nq_d;
    qam_mode_e                s1_mode_q, s1_mode_d;
    logic signed [DATA_W-1:0] s1_ref_q, s1_ref_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] inph_q, inph_d;
    logic signed [DATA_W-1:0] quad_q, quad_d;

    logic [1:0]               bpa_cur;
    logic [1:0]               bpa_s1;
    logic                     legal_s1;
    logic [MAX_BPA-1:0]       gray_inph, gray_quad;
    logic [MAX_BPA-1:0]       idx_inph, idx_quad;
    logic signed [DATA_W-1:0] amp_inph, amp_quad;

    assign bpa_cur   = mode_to_bpa(cfg_mode_q);
    assign bpa_s1    = mode_to_bpa(s1_mode_q);
    assign legal_s1  = mode_ok(s1_mode_q);
    assign gray_inph = data[MAX_BPA-1:0];
    assign gray_quad = MAX_BPA'(data >> bpa_cur);

    qam_axis_level #(.DATA_W(DATA_W), .MAX_BPA(MAX_BPA)) u_axis_inph (
        .gray_i     (gray_inph),
        .bpa_i      (bpa_cur),
        .idx_o      (idx_inph),
        .idx_s1_i   (s1_ni_q),
        .bpa_s1_i   (bpa_s1),
        .legal_s1_i (legal_s1),
        .ref_s1_i   (s1_ref_q),
        .amp_o      (amp_inph)
    );

    qam_axis_level #(.DATA_W(DATA_W), .MAX_BPA(MAX_BPA)) u_axis_quad (
        .gray_i     (gray_quad),
        .bpa_i      (bpa_cur),
        .idx_o      (idx_quad),
        .idx_s1_i   (s1_nq_q),
        .bpa_s1_i   (bpa_s1),
        .legal_s1_i (legal_s1),
        .ref_s1_i   (s1_ref_q),
        .amp_o      (amp_quad)
    );

    always_comb begin
        cfg_mode_d  = cfg_mode_q;
        cfg_ref_d   = cfg_ref_q;
        cfg_err_d   = cfg_err_q;
        s1_valid_d  = s1_valid_q;
        s1_ni_d     = s1_ni_q;
        s1_nq_d     = s1_nq_q;
        s1_mode_d   = s1_mode_q;
        s1_ref_d    = s1_ref_q;
        out_valid_d = out_valid_q;
        inph_d      = inph_q;
        quad_d      = quad_q;
        if (cfg_load) begin
            cfg_mode_d = qam_mode_e'(mode_in);
            cfg_ref_d  = ref_level;
            if (!mode_ok(qam_mode_e'(mode_in))) cfg_err_d = 1'b1;
        end
        if (clk_en) begin
            s1_valid_d  = in_valid;
            s1_ni_d     = idx_inph;
            s1_nq_d     = idx_quad;
            s1_mode_d   = cfg_mode_q;
            s1_ref_d    = cfg_ref_q;
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                inph_d = amp_inph;
                quad_d = amp_quad;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_mode_q  <= QAM_MODE_16;
            cfg_ref_q   <= '0;
            cfg_err_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_ni_q     <= '0;
            s1_nq_q     <= '0;
            s1_mode_q   <= QAM_MODE_16;
            s1_ref_q    <= '0;
            out_valid_q <= 1'b0;
            inph_q      <= '0;
            quad_q      <= '0;
        end else begin
            cfg_mode_q  <= cfg_mode_d;
            cfg_ref_q   <= cfg_ref_d;
            cfg_err_q   <= cfg_err_d;
            s1_valid_q  <= s1_valid_d;
            s1_ni_q     <= s1_ni_d;
            s1_nq_q     <= s1_nq_d;
            s1_mode_q   <= s1_mode_d;
            s1_ref_q    <= s1_ref_d;
            out_valid_q <= out_valid_d;
            inph_q      <= inph_d;
            quad_q      <= quad_d;
        end
    end

    assign sig_inph  = inph_q;
    assign sig_quad  = quad_q;
    assign out_valid = out_valid_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_qam_mapper_param.sv
// Directed bench for qam_mapper_param: hand-computed constellation points,
// pipeline latency, stalls, bubbles, reconfiguration, saturation and reset.
module tb_qam_mapper_param;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               clk_en;
    logic               in_valid;
    logic [5:0]         data;
    logic               cfg_load;
    logic [1:0]         mode_in;
    logic signed [17:0] ref_level;
    logic signed [17:0] sig_inph;
    logic signed [17:0] sig_quad;
    logic               out_valid;
    logic               cfg_err;

    int checks = 0;
    int errors = 0;

    // 16-QAM levels for ref=1000, indexed by the Gray pair: 00,01,10,11
    int lvl16 [4] = '{1500, 500, -1500, -500};

    qam_mapper_param #(.DATA_W(18), .MAX_BPA(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_en    (clk_en),
        .in_valid  (in_valid),
        .data      (data),
        .cfg_load  (cfg_load),
        .mode_in   (mode_in),
        .ref_level (ref_level),
        .sig_inph  (sig_inph),
        .sig_quad  (sig_quad),
        .out_valid (out_valid),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int ov, input int ei, input int eq);
        chk({tag, "_ov"}, out_valid, ov);
        chk({tag, "_i"}, sig_inph, ei);
        chk({tag, "_q"}, sig_quad, eq);
    endtask

    // Load config with clk_en low, map one symbol, check it two enables later.
    task automatic one(input logic [1:0] m, input logic signed [17:0] r, input logic [5:0] d,
                       input int ei, input int eq, input string tag);
        clk_en = 1'b0; cfg_load = 1'b1; mode_in = m; ref_level = r; in_valid = 1'b0;
        tick();
        cfg_load = 1'b0; clk_en = 1'b1; in_valid = 1'b1; data = d;
        tick();
        in_valid = 1'b0;
        tick();
        chk_out(tag, 1, ei, eq);
    endtask

    initial begin
        reset_n = 1'b0; clk_en = 1'b1; in_valid = 1'b1; data = '0;
        cfg_load = 1'b0; mode_in = 2'd0; ref_level = 18'sd500;
        tick();
        tick();
        chk_out("rst", 0, 0, 0);
        chk("rst_err", cfg_err, 0);
        reset_n = 1'b1; in_valid = 1'b0;

        // 16-QAM sweep
        cfg_load = 1'b1; mode_in = 2'd1; ref_level = 18'sd1000;
        tick();
        cfg_load = 1'b0;
        for (int j = 0; j < 16; j++) begin
            in_valid = 1'b1; data = 6'(j);
            tick();
            if (j == 0) chk("lat_ov0", out_valid, 0);
            else chk_out($sformatf("sw%0d", j - 1), 1, lvl16[(j - 1) % 4], lvl16[(j - 1) / 4]);
        end
        in_valid = 1'b0;
        tick();
        chk_out("sw15", 1, -500, -500);
        tick();
        chk_out("sw_drain", 0, -500, -500);

        one(2'd2, 18'sd200, 6'b000100, -700, 700, "q64");
        one(2'd0, 18'sd200, 6'b111101, -100, 100, "qpsk");
        one(2'd2, 18'sd131071, 6'b000000, 131071, 131071, "sat_pos");
        one(2'd2, 18'sd131071, 6'b100100, -131071, -131071, "sat_neg");

        // Reconfigure while two 16-QAM symbols are in flight
        cfg_load = 1'b1; mode_in = 2'd1; ref_level = 18'sd1000; clk_en = 1'b1; in_valid = 1'b0;
        tick();
        cfg_load = 1'b0; in_valid = 1'b1; data = 6'b000000;
        tick();
        data = 6'b000101; cfg_load = 1'b1; mode_in = 2'd2; ref_level = 18'sd2000;
        tick();
        chk_out("cfgA", 1, 1500, 1500);
        cfg_load = 1'b0; data = 6'b000000;
        tick();
        chk_out("cfgB", 1, 500, 500);
        in_valid = 1'b0;
        tick();
        chk_out("cfgC", 1, 7000, 7000);

        // Stall with clk_en toggling 1010
        cfg_load = 1'b1; mode_in = 2'd1; ref_level = 18'sd1000;
        tick();
        cfg_load = 1'b0;
        clk_en = 1'b1; in_valid = 1'b1; data = 6'd0;
        tick();
        clk_en = 1'b0; data = 6'd15;
        tick();
        clk_en = 1'b1;
        tick();
        chk_out("st_a", 1, 1500, 1500);
        clk_en = 1'b0; in_valid = 1'b0;
        tick();
        chk_out("st_hold_a", 1, 1500, 1500);
        clk_en = 1'b1;
        tick();
        chk_out("st_b", 1, -500, -500);
        clk_en = 1'b0;
        tick();
        chk_out("st_hold_b", 1, -500, -500);
        clk_en = 1'b1;
        tick();
        chk_out("st_drain", 0, -500, -500);
        clk_en = 1'b0;
        tick();
        chk_out("st_hold_drain", 0, -500, -500);

        // Single bubble
        clk_en = 1'b1; in_valid = 1'b1; data = 6'd0;
        tick();
        in_valid = 1'b0;
        tick();
        chk_out("bub_a", 1, 1500, 1500);
        in_valid = 1'b1; data = 6'd15;
        tick();
        chk_out("bub_gap", 0, 1500, 1500);
        in_valid = 1'b0;
        tick();
        chk_out("bub_b", 1, -500, -500);

        // Illegal mode
        cfg_load = 1'b1; mode_in = 2'd3; ref_level = 18'sd1000;
        tick();
        cfg_load = 1'b0;
        chk("ill_err", cfg_err, 1);
        in_valid = 1'b1; data = 6'd0;
        tick();
        in_valid = 1'b0;
        tick();
        chk_out("ill", 1, 0, 0);

        // Asynchronous reset mid-stream
        cfg_load = 1'b1; mode_in = 2'd2; ref_level = 18'sd1000;
        tick();
        cfg_load = 1'b0;
        chk("err_sticky", cfg_err, 1);
        in_valid = 1'b1; data = 6'd0;
        tick();
        tick();
        chk_out("pre_rst", 1, 3500, 3500);
        #2 reset_n = 1'b0;
        #1;
        chk_out("arst", 0, 0, 0);
        chk("arst_err", cfg_err, 0);
        in_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_ov0", out_valid, 0);
        tick();
        chk("post_rst_ov1", out_valid, 0);
        chk("post_rst_mode", dut.cfg_mode_q, 1);
        in_valid = 1'b1; data = 6'd0;
        tick();
        in_valid = 1'b0;
        tick();
        chk_out("post_rst_sym", 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qam_mapper_param.md
# qam_mapper_param

Parametrised square-QAM symbol mapper: converts a Gray-coded bit group into signed in-phase and quadrature amplitudes scaled by a runtime reference level. Supports QPSK, 16-QAM and 64-QAM, selected at runtime. It sits between the symbol source and the pulse-shaping filter, and replaces the fixed 16-QAM mapper. Adds a two-stage registered pipeline, valid tracking, atomic configuration updates and saturation.

## Interface
- DATA_W, 18: width of ref_level and of both outputs (signed).
- MAX_BPA, 3: maximum bits per axis. 3 allows up to 64-QAM. Legal range is 1..3.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  symbol-rate enable. All state advances only when it is high.
- in_valid  in  1  data holds a symbol to map this enable cycle.
- data  in  2*MAX_BPA  symbol bits. I uses data[b-1:0] and Q uses data[2b-1:b], where b is the active bits per axis. Unused upper bits are ignored.
- cfg_load  in  1  one-cycle strobe. Captures mode_in and ref_level into the active configuration.
- mode_in  in  2  0 = QPSK (b=1), 1 = 16-QAM (b=2), 2 = 64-QAM (b=3), 3 = illegal.
- ref_level  in  DATA_W  signed reference level, non-negative in normal use. Sets the spacing between adjacent levels.
- sig_inph  out  DATA_W  signed I amplitude, registered.
- sig_quad  out  DATA_W  signed Q amplitude, registered.
- out_valid  out  1  sig_inph and sig_quad hold a mapped symbol.
- cfg_err  out  1  sticky flag. Set when an illegal mode is loaded.

## Operation
- **Configuration registers.** cfg_mode and cfg_ref are captured on a clk edge with cfg_load=1, regardless of clk_en.
  - The new values apply to symbols accepted on the next enable cycle and later.
  - Symbols already in the pipeline keep the mode and ref they were accepted with, because both are carried with them through the pipeline.
- **cfg_err.** Set when cfg_load captures mode_in=3. It clears only on reset. While cfg_mode=3, accepted symbols produce sig_inph = sig_quad = 0 with out_valid=1.
- **Per-axis mapping.**
  - Take the b-bit Gray group g and convert it to binary: n = gray2bin(g).
  - Level index k = (2^b − 1) − 2n, an odd value in ±{1, 3, …, 2^b − 1}.
  - Amplitude = k · (ref >>> 1), where ref >>> 1 is an arithmetic shift.
  - For b=2 this gives 00→+3h, 01→+1h, 11→−1h, 10→−3h, with h = ref >>> 1.
  - For b=1: 0→+h, 1→−h.
  - For b=3: 000→+7h, 001→+5h, 011→+3h, 010→+h, 110→−h, 111→−3h, 101→−5h, 100→−7h.
- **Arithmetic.** Full-precision product, DATA_W + 3 bits, then saturate to [−(2^(DATA_W−1) − 1), +(2^(DATA_W−1) − 1)]. This range is symmetric; the most negative code is never produced.

## Timing
- **Reset.** While reset_n=0:
  - sig_inph, sig_quad, out_valid and cfg_err are 0.
  - Pipeline valids are cleared.
  - cfg_mode = 1 (16-QAM) and cfg_ref = 0.
  - Releasing reset mid-stream discards any in-flight symbols.
- **Stage 1.** On an edge with clk_en=1, the stage captures in_valid, the Gray-decoded indices, cfg_mode and cfg_ref.
- **Stage 2.** On the next edge with clk_en=1, it captures the multiply/saturate result and the valid bit into the outputs.
- **Latency.** 2 enable cycles from accept to out_valid.
- **Throughput.** 1 symbol per enable cycle.
- **Stalling.** With clk_en=0, all registers hold, including out_valid and the outputs.
- **Bubbles.** in_valid=0 on an enable cycle creates a bubble. out_valid goes 0 two enable cycles later, and the outputs hold their last values.
- **cfg_load and in_valid in the same cycle.** The symbol accepted that cycle uses the old configuration; the new configuration applies from the following enable cycle.

## Structure
- **Shared package** qam_pkg holds:
  - mode encodings (QAM_MODE_QPSK, QAM_MODE_16, QAM_MODE_64);
  - the function mode_to_bpa;
  - the function gray2bin;
  - the saturation limit constants for DATA_W.
- **Sub-module** qam_axis_level, instantiated twice (I and Q). It contains the Gray decode, the odd-index generation, the multiply and the saturation. The top level holds the configuration registers, the pipeline valids and the cfg_err flag.

## Test plan
- **16-QAM sweep.** Reset, cfg_load mode=1 with ref=1000, then stream data 0..15 with clk_en=1.
  - data=0000 gives (+1500, +1500).
  - data=0111 gives I=−500 and Q=+500.
  - out_valid rises exactly 2 cycles after the first in_valid.
- **64-QAM and QPSK.** mode=2 with ref=200: data=6'b000100 gives I=−700 and Q=+700. mode=0 with ref=200: data=2'b01 gives I=−100 and Q=+100.
- **Saturation.** mode=2 with ref=131071, data=0: both outputs are +131071. data=6'b100100: both outputs are −131071.
- **Mid-stream configuration change.** Issue cfg_load mode 1→2 while two 16-QAM symbols are in flight. Those two emerge with 16-QAM levels; the next symbol uses 64-QAM levels.
- **Stall, bubble and illegal mode.**
  - Toggle clk_en in a 1010 pattern: outputs and out_valid hold during low cycles.
  - in_valid=0 gap: out_valid drops for exactly 1 enable cycle.
  - cfg_load mode=3: cfg_err=1, and subsequent outputs are (0, 0) with out_valid=1.
- **Asynchronous reset.** Assert reset_n=0 mid-stream, between clock edges. All outputs go to 0 immediately. After release, no stale symbol appears and cfg_mode reads back as 16-QAM.
